// File: rtl/response_stage_pkg.sv
// Shared MPT walker types used by the response stage: walk transaction, packed response,
// and the flush FSM encoding.
package response_stage_pkg;

    typedef enum logic [1:0] {
        MPT_WALKING_IDLE = 2'd0,
        MPT_WALKING_DO   = 2'd1,
        MPT_WALKING_DONE = 2'd2,
        MPT_WALKING_ERR  = 2'd3
    } mpt_walking_e;

    typedef enum logic [2:0] {
        NO_ERROR        = 3'd0,
        NOT_VALID_ADDR  = 3'd1,
        RESERVED_FORMAT = 3'd2,
        MISALIGNED_PPN  = 3'd3,
        LEVEL_OVERFLOW  = 3'd4
    } page_format_fault_e;

    typedef union packed {
        logic [23:0] raw;
        struct packed {
            logic [11:0] ppn;
            logic [11:0] offset;
        } f;
    } spa_t_u;

    typedef struct packed {
        logic               valid;
        mpt_walking_e       walking;
        page_format_fault_e format_error;
        logic [1:0]         access_error;
        spa_t_u             spa;
    } mptw_transaction_t;

    typedef struct packed {
        logic               allow;
        page_format_fault_e format;
        logic [1:0]         access_err;
        spa_t_u             spa;
    } mptw_resp_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } resp_fsm_e;

    // Access is granted only for a clean walk that actually ran.
    function automatic mptw_resp_t pack_resp(mptw_transaction_t t);
        mptw_resp_t r;
        r.allow      = (t.format_error == NO_ERROR) && (t.access_error == 2'b00) &&
                       (t.walking == MPT_WALKING_DO);
        r.format     = t.format_error;
        r.access_err = t.access_error;
        r.spa        = t.spa;
        return r;
    endfunction

endpackage

// File: rtl/response_stage_resp_fifo.sv
// Synchronous FIFO of packed walker responses; head is read straight from the storage flops.
// Pointers wrap naturally because DEPTH is a power of two.
module resp_fifo
    import response_stage_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  mptw_resp_t       push_data,
    input  logic             pop,
    input  logic             clear,
    output mptw_resp_t       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    mptw_resp_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/response_stage.sv
// Last MPT walker stage: turns completed walks into allow/deny responses queued in a small FIFO,
// runs the flush handshake and counts denied responses delivered to the requester.
module response_stage
    import response_stage_pkg::*;
#(
    parameter int PIPELINE_SLAVE_DATA_WIDTH = 32,
    parameter int RESP_FIFO_DEPTH           = 4,
    parameter int FAULT_CNT_WIDTH           = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_allow_o,
    output logic [$bits(page_format_fault_e)-1:0] resp_format_o,
    output logic [1:0]                            resp_access_err_o,
    output logic [$bits(spa_t_u)-1:0]             resp_spa_o,
    input  logic                                  flush_i,
    output logic                                  flush_done_o,
    output logic [FAULT_CNT_WIDTH-1:0]            fault_cnt_o,
    output resp_fsm_e                             fsm_state_o
);

    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

    // Handshake: a slave transfer happens when stage_slave_valid && stage_slave_ready,
    // a response transfer when resp_valid_o && resp_ready_i; neither ready looks at its valid.
    mptw_transaction_t txn;
    mptw_resp_t        head;
    resp_fsm_e         state_q;
    resp_fsm_e         state_d;
    logic              live_q;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign txn = stage_slave_data;

    // Holds ready low through reset and for the first edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    assign stage_slave_ready = live_q && (state_q == RUN) &&
                               (fifo_count < CNT_W'(RESP_FIFO_DEPTH));
    assign resp_valid_o      = !fifo_empty && (state_q == RUN);

    // A transfer coinciding with a flush request is consumed but not queued.
    assign fifo_push  = stage_slave_valid && stage_slave_ready && txn.valid && !flush_i &&
                        !fifo_full;
    assign fifo_pop   = resp_valid_o && resp_ready_i;
    assign fifo_clear = (state_q == FLUSH);

    resp_fifo #(
        .DEPTH(RESP_FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (fifo_push),
        .push_data(pack_resp(txn)),
        .pop      (fifo_pop),
        .clear    (fifo_clear),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = flush_i ? FLUSH : RUN;
            FLUSH:   state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_o <= '0;
        end else if (fifo_pop && !head.allow && (fault_cnt_o != '1)) begin
            fault_cnt_o <= fault_cnt_o + 1'b1;
        end
    end

    // Response fields read as zero whenever no response is offered.
    assign resp_allow_o      = resp_valid_o & head.allow;
    assign resp_format_o     = resp_valid_o ? head.format : '0;
    assign resp_access_err_o = resp_valid_o ? head.access_err : '0;
    assign resp_spa_o        = resp_valid_o ? head.spa.raw : '0;
    assign flush_done_o      = (state_q == DONE);
    assign fsm_state_o       = state_q;

endmodule

// File: tb/tb_response_stage.sv
// Self-checking bench for response_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the response path.
module tb_response_stage;
    import response_stage_pkg::*;

    localparam int DW        = $bits(mptw_transaction_t);
    localparam int RW        = $bits(mptw_resp_t);
    localparam int DEPTH     = 4;
    localparam int FCW       = 2;
    localparam int FAULT_MAX = (1 << FCW) - 1;

    logic              clk = 1'b0;
    logic              rst_i;
    mptw_transaction_t drv_txn;
    logic              drv_valid;
    logic              stage_slave_ready;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_allow_o;
    logic [2:0]        resp_format_o;
    logic [1:0]        resp_access_err_o;
    logic [23:0]       resp_spa_o;
    logic              flush_i;
    logic              flush_done_o;
    logic [FCW-1:0]    fault_cnt_o;
    resp_fsm_e         fsm_state_o;
    logic [RW-1:0]     head;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];
    int exp_fault = 0;

    always #5 clk = ~clk;

    response_stage #(
        .PIPELINE_SLAVE_DATA_WIDTH(DW),
        .RESP_FIFO_DEPTH          (DEPTH),
        .FAULT_CNT_WIDTH          (FCW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .stage_slave_data (drv_txn),
        .stage_slave_valid(drv_valid),
        .stage_slave_ready(stage_slave_ready),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_allow_o     (resp_allow_o),
        .resp_format_o    (resp_format_o),
        .resp_access_err_o(resp_access_err_o),
        .resp_spa_o       (resp_spa_o),
        .flush_i          (flush_i),
        .flush_done_o     (flush_done_o),
        .fault_cnt_o      (fault_cnt_o),
        .fsm_state_o      (fsm_state_o)
    );

    assign head = {resp_allow_o, resp_format_o, resp_access_err_o, resp_spa_o};

    // Expected response: granted only for a clean walk in the DO state.
    function automatic logic [RW-1:0] ref_resp(mptw_transaction_t t);
        logic allow;
        allow = (t.format_error == NO_ERROR) && (t.access_error == 2'b00) &&
                (t.walking == MPT_WALKING_DO);
        return {allow, 3'(t.format_error), t.access_error, t.spa.raw};
    endfunction

    function automatic mptw_transaction_t mk_txn(logic v, logic [1:0] w, logic [2:0] f,
                                                 logic [1:0] a, logic [23:0] s);
        mptw_transaction_t t;
        t.valid        = v;
        t.walking      = mpt_walking_e'(w);
        t.format_error = page_format_fault_e'(f);
        t.access_error = a;
        t.spa.raw      = s;
        return t;
    endfunction

    function automatic mptw_transaction_t rand_txn();
        logic [1:0] w;
        logic [2:0] f;
        logic [1:0] a;
        w = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
        f = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        a = ($urandom_range(0, 2) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
        return mk_txn($urandom_range(0, 4) != 0, w, f, a, 24'($urandom));
    endfunction

    function automatic void model_pop();
        logic [RW-1:0] r;
        r = exp_q.pop_front();
        if (!r[RW-1] && exp_fault < FAULT_MAX) exp_fault++;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; drv_valid = 1'b0; drv_txn = '0; resp_ready_i = 1'b0; flush_i = 1'b0;
        step(); step();
        total++;
        if ({stage_slave_ready, resp_valid_o, head, flush_done_o, fault_cnt_o, fsm_state_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got rdy=%b vld=%b head=%h done=%b cnt=%0d",
                            stage_slave_ready, resp_valid_o, head, flush_done_o, fault_cnt_o);
        end
        #2 rst_i = 1'b0;
        total++;
        if (stage_slave_ready !== 1'b0) begin
            bad++; $display("FAIL ready_at_release: got %b want 0", stage_slave_ready);
        end
        step();
        total++;
        if (stage_slave_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release: got %b want 1", stage_slave_ready);
        end
        drv_valid = 1'b1;
        drv_txn = mk_txn(1'b1, 2'd1, 3'd0, 2'd0, 24'h00abcd);
        step();
        drv_txn = mk_txn(1'b1, 2'd1, 3'd1, 2'd0, 24'h000077);
        step();
        drv_valid = 1'b0;
        total++;
        if (resp_valid_o !== 1'b1) begin
            bad++; $display("FAIL valid_before_reset: got %b want 1", resp_valid_o);
        end
        #2 rst_i = 1'b1;
        #1;
        total++;
        if ({stage_slave_ready, resp_valid_o, head, flush_done_o, fault_cnt_o, fsm_state_o} !== '0) begin
            bad++; $display("FAIL async_reset_outputs: got rdy=%b vld=%b head=%h cnt=%0d",
                            stage_slave_ready, resp_valid_o, head, fault_cnt_o);
        end
        step();
        #2 rst_i = 1'b0;
        step(); step();
        total++;
        if (resp_valid_o !== 1'b0 || stage_slave_ready !== 1'b1 || fault_cnt_o !== '0) begin
            bad++; $display("FAIL discard_on_reset: got vld=%b rdy=%b cnt=%0d want 0 1 0",
                            resp_valid_o, stage_slave_ready, fault_cnt_o);
        end
        exp_q.delete();
        exp_fault = 0;
    endtask

    task automatic test_latency_allow();
        drv_txn = mk_txn(1'b1, 2'd1, 3'd0, 2'd0, 24'h001234);
        drv_valid = 1'b1;
        total++;
        if (stage_slave_ready !== 1'b1 || resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL latency_pre: got rdy=%b vld=%b want 1 0", stage_slave_ready, resp_valid_o);
        end
        step();
        drv_valid = 1'b0;
        total++;
        if (resp_valid_o !== 1'b1) begin
            bad++; $display("FAIL latency_valid: got %b want 1", resp_valid_o);
        end
        total++;
        if (head !== ref_resp(drv_txn) || resp_allow_o !== 1'b1 || resp_spa_o !== 24'h001234) begin
            bad++; $display("FAIL latency_fields: got %h want %h", head, ref_resp(drv_txn));
        end
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        total++;
        if (resp_valid_o !== 1'b0 || fault_cnt_o !== FCW'(exp_fault)) begin
            bad++; $display("FAIL latency_pop: got vld=%b cnt=%0d want 0 %0d", resp_valid_o, fault_cnt_o, exp_fault);
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 4; i++) begin
            drv_txn = rand_txn();
            drv_txn.valid = 1'b0;
            drv_valid = 1'b1;
            total++;
            if (stage_slave_ready !== 1'b1) begin
                bad++; $display("FAIL bubble_ready: got %b want 1", stage_slave_ready);
            end
            step();
            total++;
            if (resp_valid_o !== 1'b0 || fault_cnt_o !== FCW'(exp_fault)) begin
                bad++; $display("FAIL bubble_drop: got vld=%b cnt=%0d want 0 %0d", resp_valid_o, fault_cnt_o, exp_fault);
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        mptw_transaction_t txns[5];
        int idx = 0;
        logic ev, er;
        for (int i = 0; i < 5; i++) begin
            txns[i] = rand_txn();
            txns[i].valid = 1'b1;
        end
        resp_ready_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ev = exp_q.size() > 0;
            er = exp_q.size() < DEPTH;
            if (c == 10) begin
                total++;
                if (idx != 4 || stage_slave_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_stall: got accepted=%0d rdy=%b want 4 0", idx, stage_slave_ready);
                end
            end
            total++;
            if (stage_slave_ready !== er || resp_valid_o !== ev) begin
                bad++; $display("FAIL bp_handshake: got rdy=%b vld=%b want %b %b", stage_slave_ready, resp_valid_o, er, ev);
            end
            if (ev) begin
                total++;
                if (head !== exp_q[0]) begin
                    bad++; $display("FAIL bp_head: got %h want %h", head, exp_q[0]);
                end
            end
            resp_ready_i = (c >= 10);
            drv_valid = (idx < 5);
            drv_txn = txns[(idx < 5) ? idx : 4];
            if (ev && resp_ready_i) model_pop();
            if (er && drv_valid) begin
                exp_q.push_back(ref_resp(txns[idx]));
                idx++;
            end
            step();
        end
        total++;
        if (idx != 5 || exp_q.size() != 0 || fault_cnt_o !== FCW'(exp_fault)) begin
            bad++; $display("FAIL bp_all_delivered: got accepted=%0d left=%0d cnt=%0d want 5 0 %0d",
                            idx, exp_q.size(), fault_cnt_o, exp_fault);
        end
        resp_ready_i = 1'b0;
        drv_valid = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drv_txn = rand_txn();
            drv_txn.valid = 1'b1;
            drv_valid = 1'b1;
            exp_q.push_back(ref_resp(drv_txn));
            step();
        end
        drv_txn = rand_txn();
        drv_txn.valid = 1'b1;
        flush_i = 1'b1;
        resp_ready_i = 1'b1;
        total++;
        if (resp_valid_o !== 1'b1 || head !== exp_q[0]) begin
            bad++; $display("FAIL flush_pop_head: got vld=%b head=%h want 1 %h", resp_valid_o, head, exp_q[0]);
        end
        model_pop();
        step();
        flush_i = 1'b0;
        drv_valid = 1'b0;
        total++;
        if (resp_valid_o !== 1'b0 || stage_slave_ready !== 1'b0 || flush_done_o !== 1'b0 ||
            fault_cnt_o !== FCW'(exp_fault)) begin
            bad++; $display("FAIL flush_cycle: got vld=%b rdy=%b done=%b cnt=%0d want 0 0 0 %0d",
                            resp_valid_o, stage_slave_ready, flush_done_o, fault_cnt_o, exp_fault);
        end
        step();
        total++;
        if (flush_done_o !== 1'b1 || stage_slave_ready !== 1'b0 || resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_done_pulse: got done=%b rdy=%b vld=%b want 1 0 0",
                            flush_done_o, stage_slave_ready, resp_valid_o);
        end
        exp_q.delete();
        step();
        total++;
        if (flush_done_o !== 1'b0 || stage_slave_ready !== 1'b1 || resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_back_to_run: got done=%b rdy=%b vld=%b want 0 1 0",
                            flush_done_o, stage_slave_ready, resp_valid_o);
        end
        step();
        total++;
        if (resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_empty: got vld=%b want 0", resp_valid_o);
        end
        resp_ready_i = 1'b0;
    endtask

    task automatic test_random();
        int phase = 0;  // 0 running, 2 flushing, 1 flush-done cycle
        logic ev, er;
        for (int c = 0; c < 500; c++) begin
            ev = (phase == 0) && (exp_q.size() > 0);
            er = (phase == 0) && (exp_q.size() < DEPTH);
            total++;
            if (stage_slave_ready !== er || resp_valid_o !== ev) begin
                bad++; $display("FAIL rnd_handshake c=%0d: got rdy=%b vld=%b want %b %b",
                                c, stage_slave_ready, resp_valid_o, er, ev);
            end
            total++;
            if (flush_done_o !== (phase == 1)) begin
                bad++; $display("FAIL rnd_flush_done c=%0d: got %b want %b", c, flush_done_o, phase == 1);
            end
            if (ev) begin
                total++;
                if (head !== exp_q[0]) begin
                    bad++; $display("FAIL rnd_head c=%0d: got %h want %h", c, head, exp_q[0]);
                end
            end
            total++;
            if (fault_cnt_o !== FCW'(exp_fault)) begin
                bad++; $display("FAIL rnd_fault_cnt c=%0d: got %0d want %0d", c, fault_cnt_o, exp_fault);
            end
            drv_valid = $urandom_range(0, 3) != 0;
            drv_txn = rand_txn();
            resp_ready_i = $urandom_range(0, 2) != 0;
            flush_i = $urandom_range(0, 24) == 0;
            if (ev && resp_ready_i) model_pop();
            if (er && drv_valid && drv_txn.valid && !flush_i) exp_q.push_back(ref_resp(drv_txn));
            if (phase == 2) begin
                exp_q.delete();
                phase = 1;
            end else if (phase == 1) begin
                phase = 0;
            end else if (flush_i) begin
                phase = 2;
            end
            step();
        end
        flush_i = 1'b0;
        drv_valid = 1'b0;
        resp_ready_i = 1'b0;
    endtask

    task automatic test_saturation();
        rst_i = 1'b1;
        step();
        #2 rst_i = 1'b0;
        step();
        exp_q.delete();
        exp_fault = 0;
        total++;
        if (fault_cnt_o !== '0) begin
            bad++; $display("FAIL sat_start: got %0d want 0", fault_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            drv_txn = mk_txn(1'b1, 2'd1, 3'd1, 2'd0, 24'($urandom));
            drv_valid = 1'b1;
            step();
            drv_valid = 1'b0;
            total++;
            if (resp_valid_o !== 1'b1 || resp_allow_o !== 1'b0 || resp_format_o !== 3'd1) begin
                bad++; $display("FAIL sat_deny i=%0d: got vld=%b allow=%b fmt=%0d want 1 0 1",
                                i, resp_valid_o, resp_allow_o, resp_format_o);
            end
            resp_ready_i = 1'b1;
            step();
            resp_ready_i = 1'b0;
            exp_fault = (i + 1 > FAULT_MAX) ? FAULT_MAX : i + 1;
            total++;
            if (fault_cnt_o !== FCW'(exp_fault)) begin
                bad++; $display("FAIL sat_count i=%0d: got %0d want %0d", i, fault_cnt_o, exp_fault);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency_allow();
        test_bubble();
        test_back_pressure();
        test_flush();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
